// File: rtl/pad_monitor_pkg.sv
// pad_monitor shared types: register offsets, register index, bus structs.
// Optional debounce logic is built when PAD_MONITOR_DEBOUNCE_EN is defined.
package pad_monitor_pkg;

  localparam int unsigned PAD_MONITOR_MAX_PAD = 32;

  localparam logic [31:0] PAD_MONITOR_LEVEL_OFFSET    = 32'h00;
  localparam logic [31:0] PAD_MONITOR_RISE_EN_OFFSET  = 32'h04;
  localparam logic [31:0] PAD_MONITOR_FALL_EN_OFFSET  = 32'h08;
  localparam logic [31:0] PAD_MONITOR_STATUS_OFFSET   = 32'h0C;
  localparam logic [31:0] PAD_MONITOR_DEBOUNCE_OFFSET = 32'h10;

  typedef enum logic [2:0] {
    REG_LEVEL,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_STATUS,
    REG_DEBOUNCE,
    REG_NONE
  } reg_idx_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } pad_monitor_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } pad_monitor_rsp_t;

  function automatic reg_idx_e reg_decode(logic [31:0] addr);
    reg_idx_e idx;
    unique case (1'b1)
      addr == PAD_MONITOR_LEVEL_OFFSET:    idx = REG_LEVEL;
      addr == PAD_MONITOR_RISE_EN_OFFSET:  idx = REG_RISE_EN;
      addr == PAD_MONITOR_FALL_EN_OFFSET:  idx = REG_FALL_EN;
      addr == PAD_MONITOR_STATUS_OFFSET:   idx = REG_STATUS;
      addr == PAD_MONITOR_DEBOUNCE_OFFSET: idx = REG_DEBOUNCE;
      default:                             idx = REG_NONE;
    endcase
    return idx;
  endfunction

  function automatic logic [31:0] strb_mask(logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pad_monitor_debounce.sv
// Single-pad 2-flop synchronizer plus optional debounce to a stable level.
// Counter is built only when PAD_MONITOR_DEBOUNCE_EN is defined.
module pad_monitor_debounce
  import pad_monitor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pad,
  input  logic [DEBOUNCE_W-1:0] limit,
  output logic                  level
);

  logic [1:0] sync_q;
  logic       level_q;
  logic       level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pad};
      level_q <= level_d;
    end
  end

`ifdef PAD_MONITOR_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cnt_q;
  logic [DEBOUNCE_W-1:0] cnt_d;

  // >= rather than == so a limit lowered mid-count still resolves
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= limit) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^limit;
  assign level_d      = sync_q[1];
`endif

  assign level = level_q;

endmodule

// File: rtl/pad_monitor.sv
// Pad input monitor: debounced levels, edge-enabled sticky status, level irq.
// PAD_MONITOR_DEBOUNCE_EN enables the DEBOUNCE register and per-pad counters.
module pad_monitor
  import pad_monitor_pkg::*;
#(
  parameter type         reg_req_t  = pad_monitor_req_t,
  parameter type         reg_rsp_t  = pad_monitor_rsp_t,
  parameter int unsigned NUM_PAD    = 1,
  parameter int unsigned DEBOUNCE_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  reg_req_t           reg_req_i,
  output reg_rsp_t           reg_rsp_o,
  input  logic [NUM_PAD-1:0] pad_in_i,
  output logic               intr_o
);

  logic [NUM_PAD-1:0]    level;
  logic [NUM_PAD-1:0]    level_q;
  logic [NUM_PAD-1:0]    rise_en;
  logic [NUM_PAD-1:0]    fall_en;
  logic [NUM_PAD-1:0]    status;
  logic [NUM_PAD-1:0]    rise_en_d;
  logic [NUM_PAD-1:0]    fall_en_d;
  logic [NUM_PAD-1:0]    status_d;
  logic [NUM_PAD-1:0]    events;
  logic [NUM_PAD-1:0]    clr;
  logic [DEBOUNCE_W-1:0] limit;

  reg_idx_e    idx;
  logic        wr;
  logic [31:0] mask;
  logic [31:0] wdata_m;
  logic        unused_bits;

  assign idx         = reg_decode(reg_req_i.addr);
  assign wr          = reg_req_i.valid & reg_req_i.write;
  assign mask        = strb_mask(reg_req_i.wstrb);
  assign wdata_m     = reg_req_i.wdata & mask;
  assign unused_bits = ^{wdata_m, mask};

  for (genvar g = 0; g < NUM_PAD; g++) begin : g_pad
    pad_monitor_debounce #(
      .DEBOUNCE_W(DEBOUNCE_W)
    ) u_db (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .pad  (pad_in_i[g]),
      .limit(limit),
      .level(level[g])
    );
  end

  assign events = (level & ~level_q & rise_en)
                | (~level & level_q & fall_en);

  always_comb begin
    rise_en_d = rise_en;
    fall_en_d = fall_en;
    clr       = '0;
    if (wr && idx == REG_RISE_EN) begin
      rise_en_d = (rise_en & ~mask[NUM_PAD-1:0])
                | wdata_m[NUM_PAD-1:0];
    end
    if (wr && idx == REG_FALL_EN) begin
      fall_en_d = (fall_en & ~mask[NUM_PAD-1:0])
                | wdata_m[NUM_PAD-1:0];
    end
    if (wr && idx == REG_STATUS) begin
      clr = wdata_m[NUM_PAD-1:0];
    end
    // hardware set wins over a same-cycle clear
    status_d = (status & ~clr) | events;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      level_q <= level;
      rise_en <= rise_en_d;
      fall_en <= fall_en_d;
      status  <= status_d;
    end
  end

`ifdef PAD_MONITOR_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] limit_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      limit_q <= '0;
    end else if (wr && idx == REG_DEBOUNCE) begin
      limit_q <= (limit_q & ~mask[DEBOUNCE_W-1:0])
               | wdata_m[DEBOUNCE_W-1:0];
    end
  end

  assign limit = limit_q;
`else
  assign limit = '0;
`endif

  assign intr_o = |status;

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    if (reg_req_i.valid) begin
      unique case (idx)
        REG_LEVEL:    reg_rsp_o.rdata = 32'(level);
        REG_RISE_EN:  reg_rsp_o.rdata = 32'(rise_en);
        REG_FALL_EN:  reg_rsp_o.rdata = 32'(fall_en);
        REG_STATUS:   reg_rsp_o.rdata = 32'(status);
        REG_DEBOUNCE: reg_rsp_o.rdata = 32'(limit);
        default:      reg_rsp_o.error = 1'b1;
      endcase
      if (reg_req_i.write || idx == REG_NONE) begin
        reg_rsp_o.rdata = '0;
      end
    end
  end

endmodule

// File: tb/tb_pad_monitor.sv
// Self-checking bench for pad_monitor with a queue-based scoreboard.
// Covers both builds of PAD_MONITOR_DEBOUNCE_EN.
module tb_pad_monitor;
  import pad_monitor_pkg::*;

  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  pad_monitor_req_t req;
  pad_monitor_rsp_t rsp;
  logic [NP-1:0]    pad;
  logic             intr;

  always #5 clk = ~clk;

  pad_monitor #(
    .reg_req_t (pad_monitor_req_t),
    .reg_rsp_t (pad_monitor_rsp_t),
    .NUM_PAD   (NP),
    .DEBOUNCE_W(8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .reg_req_i(req),
    .reg_rsp_o(rsp),
    .pad_in_i (pad),
    .intr_o   (intr)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic score(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", obs, 32'hDEAD_BEEF);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, input string tag,
                    input logic [31:0] d, input logic err);
    push_exp(tag, d);
    push_exp({tag, "_err"}, {31'b0, err});
    req = '{valid: 1'b1, write: 1'b0, addr: a,
            wdata: 32'h0, wstrb: 4'h0};
    #1;
    score(rsp.rdata);
    score({31'b0, rsp.error});
    req.valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string tag,
                    input logic err);
    push_exp({tag, "_werr"}, {31'b0, err});
    req = '{valid: 1'b1, write: 1'b1, addr: a, wdata: d, wstrb: s};
    #1;
    score({31'b0, rsp.error});
    @(posedge clk);
    #1;
    req.valid = 1'b0;
  endtask

  task automatic chk_intr(input string tag, input logic v);
    push_exp(tag, {31'b0, v});
    score({31'b0, intr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pad   = '0;
    req   = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    push_exp("ready", 32'h1);
    score({31'b0, rsp.ready});
    chk_intr("rst_intr", 1'b0);
    rd(PAD_MONITOR_LEVEL_OFFSET,    "rst_level",  32'h0, 1'b0);
    rd(PAD_MONITOR_RISE_EN_OFFSET,  "rst_rise",   32'h0, 1'b0);
    rd(PAD_MONITOR_FALL_EN_OFFSET,  "rst_fall",   32'h0, 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET,   "rst_status", 32'h0, 1'b0);
    rd(PAD_MONITOR_DEBOUNCE_OFFSET, "rst_deb",    32'h0, 1'b0);
    rd(32'h14, "unmapped_rd", 32'h0, 1'b1);

    // rise latency with L = 0
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'h1, 4'hF, "rise_en", 1'b0);
    pad[0] = 1'b1;
    tick(2);
    rd(PAD_MONITOR_LEVEL_OFFSET, "lvl_e1", 32'h0, 1'b0);
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "lvl_e2", 32'h1, 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "st_e2", 32'h0, 1'b0);
    chk_intr("intr_e2", 1'b0);
    tick(1);
    rd(PAD_MONITOR_STATUS_OFFSET, "st_e3", 32'h1, 1'b0);
    chk_intr("intr_e3", 1'b1);
    wr(PAD_MONITOR_STATUS_OFFSET, 32'h1, 4'hF, "w1c0", 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "st_clr0", 32'h0, 1'b0);
    chk_intr("intr_clr0", 1'b0);

`ifdef PAD_MONITOR_DEBOUNCE_EN
    wr(PAD_MONITOR_DEBOUNCE_OFFSET, 32'h3, 4'hF, "deb3", 1'b0);
    rd(PAD_MONITOR_DEBOUNCE_OFFSET, "deb3_rd", 32'h3, 1'b0);
    pad[1] = 1'b1;
    tick(3);
    pad[1] = 1'b0;
    tick(8);
    rd(PAD_MONITOR_LEVEL_OFFSET, "glitch_lvl", 32'h1, 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "glitch_st", 32'h0, 1'b0);
    pad[1] = 1'b1;
    tick(5);
    rd(PAD_MONITOR_LEVEL_OFFSET, "hold_e4", 32'h1, 1'b0);
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "hold_e5", 32'h3, 1'b0);
    wr(PAD_MONITOR_DEBOUNCE_OFFSET, 32'h0, 4'hF, "deb0", 1'b0);
    pad[1] = 1'b0;
    tick(4);
    rd(PAD_MONITOR_LEVEL_OFFSET, "hold_rel", 32'h1, 1'b0);
`else
    wr(PAD_MONITOR_DEBOUNCE_OFFSET, 32'h5, 4'hF, "deb5", 1'b0);
    rd(PAD_MONITOR_DEBOUNCE_OFFSET, "deb5_rd", 32'h0, 1'b0);
    pad[1] = 1'b1;
    tick(1);
    pad[1] = 1'b0;
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "p1_e1", 32'h1, 1'b0);
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "p1_e2", 32'h3, 1'b0);
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "p1_e3", 32'h1, 1'b0);
`endif

    // fall event racing a W1C
    wr(PAD_MONITOR_FALL_EN_OFFSET, 32'h4, 4'hF, "fall_en", 1'b0);
    pad[2] = 1'b1;
    tick(4);
    rd(PAD_MONITOR_STATUS_OFFSET, "p2_rise_st", 32'h0, 1'b0);
    pad[2] = 1'b0;
    tick(3);
    rd(PAD_MONITOR_LEVEL_OFFSET, "p2_fall_lvl", 32'h1, 1'b0);
    wr(PAD_MONITOR_STATUS_OFFSET, 32'h4, 4'hF, "w1c_race", 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "race_st", 32'h4, 1'b0);
    chk_intr("race_intr", 1'b1);
    wr(PAD_MONITOR_STATUS_OFFSET, 32'h0, 4'hF, "w0", 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "w0_st", 32'h4, 1'b0);
    wr(PAD_MONITOR_FALL_EN_OFFSET, 32'h0, 4'hF, "fall_off", 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "en_off_st", 32'h4, 1'b0);
    rd(PAD_MONITOR_FALL_EN_OFFSET, "fall_rd", 32'h0, 1'b0);
    wr(PAD_MONITOR_STATUS_OFFSET, 32'h4, 4'hF, "w1c2", 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "w1c2_st", 32'h0, 1'b0);
    chk_intr("w1c2_intr", 1'b0);

    // bus corner cases
    wr(PAD_MONITOR_LEVEL_OFFSET, 32'hFFFF, 4'hF, "lvl_wr", 1'b0);
    rd(PAD_MONITOR_LEVEL_OFFSET, "lvl_wr_rd", 32'h1, 1'b0);
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'h0, 4'hF, "rise_clr", 1'b0);
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'hFF, 4'h1, "rise_b0", 1'b0);
    rd(PAD_MONITOR_RISE_EN_OFFSET, "rise_b0_rd", 32'hF, 1'b0);
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'h0, 4'h2, "rise_b1", 1'b0);
    rd(PAD_MONITOR_RISE_EN_OFFSET, "rise_b1_rd", 32'hF, 1'b0);
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'hFF00, 4'h1, "rise_b0z", 1'b0);
    rd(PAD_MONITOR_RISE_EN_OFFSET, "rise_b0z_rd", 32'h0, 1'b0);
    wr(32'h14, 32'hFF, 4'hF, "unmapped_wr", 1'b1);
    rd(32'h20, "unmapped_rd2", 32'h0, 1'b1);

    // reset in the middle of live state
    wr(PAD_MONITOR_RISE_EN_OFFSET, 32'h2, 4'hF, "rise_p1", 1'b0);
    pad[1] = 1'b1;
    tick(4);
    rd(PAD_MONITOR_STATUS_OFFSET, "p1_st", 32'h2, 1'b0);
    chk_intr("p1_intr", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_intr("arst_intr", 1'b0);
    rd(PAD_MONITOR_LEVEL_OFFSET, "arst_lvl", 32'h0, 1'b0);
    rd(PAD_MONITOR_STATUS_OFFSET, "arst_st", 32'h0, 1'b0);
    rd(PAD_MONITOR_RISE_EN_OFFSET, "arst_rise", 32'h0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rd(PAD_MONITOR_LEVEL_OFFSET, "post_e1", 32'h0, 1'b0);
    tick(1);
    rd(PAD_MONITOR_LEVEL_OFFSET, "post_e2", 32'h3, 1'b0);
    tick(1);
    rd(PAD_MONITOR_STATUS_OFFSET, "post_st", 32'h0, 1'b0);
    chk_intr("post_intr", 1'b0);

    if (sb.size() != 0) begin
      check("sb_leftover", sb.size(), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
